eigen_recompose: RTL and testbench



---
 rtl/eigen_pkg.sv | 41 ++++
 rtl/eigen_recompose_fx_mac.sv | 62 ++++++
 rtl/eigen_recompose.sv | 176 +++++++++++++++++
 tb/tb_eigen_recompose.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eigen_pkg.sv
// Shared definitions for the eigen decompose/recompose engines.
// Holds default widths, the controller state encoding and the fixed-point
// helpers. Helpers operate on 64-bit signed values so they serve any
// WIDTH/FRAC/ACC_W combination whose intermediates fit in 64 bits.
package eigen_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned N_DEF     = 4;
  localparam int unsigned FRAC_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } state_e;

  // Full-precision product, then arithmetic shift (floor toward -inf).
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int unsigned        frac);
    logic signed [63:0] prod;
    prod = a * b;
    return prod >>> frac;
  endfunction

  // Clamp to the signed range of a width-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] acc,
                                                      input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage

// File: rtl/eigen_recompose_fx_mac.sv
// Fixed-point multiply-accumulate for one matrix element.
// Each enabled cycle adds ((q_rk*q_ck)>>>FRAC)*lambda>>>FRAC to the
// accumulator. Ports:
//   clk, rst        clock, async active-high reset
//   i_clr           clear accumulator (wins over i_en)
//   i_en            accumulate one term
//   i_q_rk, i_q_ck  eigenvector entries Q[r][k], Q[c][k]
//   i_lambda        eigenvalue k
//   o_result        accumulator saturated to WIDTH bits
module fx_mac
  import eigen_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter int unsigned ACC_W = 2 * WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_q_rk,
  input  logic signed [WIDTH-1:0] i_q_ck,
  input  logic signed [WIDTH-1:0] i_lambda,
  output logic signed [WIDTH-1:0] o_result
);

  logic signed [63:0]      w_q_rk_ext;
  logic signed [63:0]      w_q_ck_ext;
  logic signed [63:0]      w_lambda_ext;
  logic signed [63:0]      w_acc_ext;
  logic signed [63:0]      w_p;
  logic signed [63:0]      w_t;
  logic signed [63:0]      w_sat;
  logic signed [ACC_W-1:0] r_acc;

  always_comb begin
    w_q_rk_ext   = $signed({{(64 - WIDTH){i_q_rk[WIDTH-1]}}, i_q_rk});
    w_q_ck_ext   = $signed({{(64 - WIDTH){i_q_ck[WIDTH-1]}}, i_q_ck});
    w_lambda_ext = $signed({{(64 - WIDTH){i_lambda[WIDTH-1]}}, i_lambda});
    w_acc_ext    = $signed({{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc});
    w_p          = fx_mul(w_q_rk_ext, w_q_ck_ext, FRAC);
    w_t          = fx_mul(w_p, w_lambda_ext, FRAC);
    w_sat        = sat_to_width(w_acc_ext, WIDTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + $signed(w_t[ACC_W-1:0]);
    end
  end

  assign o_result = w_sat[WIDTH-1:0];

  // Upper bits are redundant sign copies once the term/clamp is in range.
  logic w_unused_hi;
  assign w_unused_hi = ^{w_sat[63:WIDTH], w_t[63:ACC_W]};

endmodule

// File: rtl/eigen_recompose.sv
// Rebuilds A = Q * diag(lambda) * Q^T using one time-multiplexed MAC.
// Walks the upper triangle pair by pair: N MAC cycles then one WRITE that
// stores the saturated sum into both mirrored positions.
// Ports:
//   clk, rst      clock, async active-high reset
//   start         request, honoured only in IDLE
//   eigenvectors  packed Q, row-major, element r*N+c
//   eigenvalues   packed D, row-major, only the diagonal is used
//   busy          high from start-accept until done
//   done          one-cycle pulse when matrix is coherent
//   matrix        reconstructed A, row-major
module eigen_recompose
  import eigen_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned N_STOCKS = N_DEF,
  parameter int unsigned FRAC     = FRAC_DEF,
  parameter int unsigned ACC_W    = 2 * WIDTH + 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [N_STOCKS*N_STOCKS*WIDTH-1:0] eigenvectors,
  input  logic [N_STOCKS*N_STOCKS*WIDTH-1:0] eigenvalues,
  output logic                               busy,
  output logic                               done,
  output logic [N_STOCKS*N_STOCKS*WIDTH-1:0] matrix
);

  localparam int unsigned IW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STOCKS - 1);

  state_e r_state;
  state_e w_state_next;

  logic signed [WIDTH-1:0] r_q      [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] r_lambda [N_STOCKS];
  logic        [WIDTH-1:0] r_mat    [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] w_q_in   [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] w_lam_in [N_STOCKS];

  logic [IW-1:0] r_r;
  logic [IW-1:0] r_c;
  logic [IW-1:0] r_k;
  logic          r_busy;
  logic          r_done;

  logic w_accept;
  logic w_mac_en;
  logic w_mac_clr;
  logic w_write;
  logic w_last_k;
  logic w_last_pair;

  logic signed [WIDTH-1:0] w_result;

  // Unpack inputs; only the diagonal of the eigenvalue matrix is kept.
  for (genvar gr = 0; gr < N_STOCKS; gr++) begin : g_unpack_row
    for (genvar gc = 0; gc < N_STOCKS; gc++) begin : g_unpack_col
      assign w_q_in[gr][gc] = eigenvectors[(gr*N_STOCKS+gc)*WIDTH +: WIDTH];
      assign matrix[(gr*N_STOCKS+gc)*WIDTH +: WIDTH] = r_mat[gr][gc];
    end
    assign w_lam_in[gr] = eigenvalues[(gr*N_STOCKS+gr)*WIDTH +: WIDTH];
  end

  logic w_unused_evals;
  assign w_unused_evals = ^eigenvalues;

  assign w_last_k    = (r_k == LAST_IDX);
  assign w_last_pair = (r_r == LAST_IDX) && (r_c == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = MAC;
      MAC:     if (w_last_k) w_state_next = WRITE;
      WRITE:   w_state_next = w_last_pair ? IDLE : MAC;
      default: w_state_next = IDLE;
    endcase
  end

  // Control strobes.
  always_comb begin
    w_accept  = 1'b0;
    w_mac_en  = 1'b0;
    w_mac_clr = 1'b0;
    w_write   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept  = start;
        w_mac_clr = start;
      end
      MAC:   w_mac_en = 1'b1;
      WRITE: begin
        w_write   = 1'b1;
        w_mac_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, pair/term counters, result storage and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r    <= '0;
      r_c    <= '0;
      r_k    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < N_STOCKS; i++) begin
        r_lambda[i] <= '0;
        for (int j = 0; j < N_STOCKS; j++) begin
          r_q[i][j]   <= '0;
          r_mat[i][j] <= '0;
        end
      end
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_q      <= w_q_in;
        r_lambda <= w_lam_in;
        r_r      <= '0;
        r_c      <= '0;
        r_k      <= '0;
        r_busy   <= 1'b1;
      end
      if (w_mac_en && !w_last_k) begin
        r_k <= r_k + 1'b1;
      end
      if (w_write) begin
        r_mat[r_r][r_c] <= w_result;
        r_mat[r_c][r_r] <= w_result;
        r_k             <= '0;
        if (r_c == LAST_IDX) begin
          r_r <= r_r + 1'b1;
          r_c <= r_r + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
        if (w_last_pair) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  fx_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_fx_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_mac_clr),
    .i_en     (w_mac_en),
    .i_q_rk   (r_q[r_r][r_k]),
    .i_q_ck   (r_q[r_c][r_k]),
    .i_lambda (r_lambda[r_k]),
    .o_result (w_result)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_eigen_recompose.sv
// Bench for eigen_recompose at default parameters: table of directed
// vectors, random vectors against an arithmetic reference, and hand-written
// sequences for start-while-busy, mid-run reset and back-to-back starts.
module tb_eigen_recompose;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MW = N * N * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [MW-1:0] eigenvectors;
  logic [MW-1:0] eigenvalues;
  logic          busy;
  logic          done;
  logic [MW-1:0] matrix;

  int n_checks;
  int n_fail;

  eigen_recompose dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .eigenvectors (eigenvectors),
    .eigenvalues  (eigenvalues),
    .busy         (busy),
    .done         (done),
    .matrix       (matrix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [MW-1:0] q;
    logic [MW-1:0] d;
    logic [MW-1:0] exp;
  } vec_t;

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c,
                                        input int v);
    logic [MW-1:0] t;
    logic [W-1:0]  e;
    t = m;
    e = W'(v);
    t[(r*N+c)*W +: W] = e;
    return t;
  endfunction

  function automatic logic [MW-1:0] fill(input int v);
    logic [MW-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) t = put(t, i, j, v);
    return t;
  endfunction

  function automatic longint el(input logic [MW-1:0] m, input int r, input int c);
    logic signed [W-1:0] e;
    longint x;
    e = m[(r*N+c)*W +: W];
    x = e;
    return x;
  endfunction

  // Division rounding toward minus infinity.
  function automatic longint floordiv(input longint x, input longint dv);
    longint q;
    q = x / dv;
    if ((x % dv != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  // A[i][j] = sum_k floor(floor(Q[i][k]*Q[j][k]/256)*lambda_k/256), clamped.
  function automatic logic [MW-1:0] model(input logic [MW-1:0] q, input logic [MW-1:0] d);
    logic [MW-1:0] a;
    longint acc;
    a = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          acc += floordiv(floordiv(el(q, i, k) * el(q, j, k), 256) * el(d, k, k), 256);
        end
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        a = put(a, i, j, int'(acc));
      end
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_matrix(input string name, input logic [MW-1:0] req);
    logic signed [W-1:0] ea;
    logic signed [W-1:0] er;
    for (int i = 0; i < N * N; i++) begin
      ea = matrix[i*W +: W];
      er = req[i*W +: W];
      chk($sformatf("%s[%0d]", name, i), ea, er);
    end
  endtask

  // Launch one computation and count edges after the accept edge until done.
  task automatic run_once(input logic [MW-1:0] q, input logic [MW-1:0] d, output int lat,
                          output int busy_drop);
    @(negedge clk);
    eigenvectors = q;
    eigenvalues  = d;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    eigenvectors = '1;  // inputs are free to change after capture
    eigenvalues  = '1;
    lat          = -1;
    busy_drop    = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_drop++;
    end
  endtask

  vec_t          vecs[4];
  logic [MW-1:0] q_id, d_id, e_id, q_rot, d_rot, e_rot, rq, rd;
  int            lat, bdrop, dcnt, first_done, second_done, bhigh;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    eigenvectors = '0;
    eigenvalues  = '0;

    // Directed vectors.
    q_id = '0;
    d_id = '0;
    e_id = '0;
    for (int i = 0; i < N; i++) begin
      q_id = put(q_id, i, i, 256);
      d_id = put(d_id, i, i, 256 * (i + 1));
      e_id = put(e_id, i, i, 256 * (i + 1));
    end
    q_rot = '0;
    q_rot = put(q_rot, 0, 0, 181);
    q_rot = put(q_rot, 1, 1, 181);
    q_rot = put(q_rot, 1, 0, 181);
    q_rot = put(q_rot, 0, 1, -181);
    q_rot = put(q_rot, 2, 2, 256);
    q_rot = put(q_rot, 3, 3, 256);
    d_rot = '0;
    d_rot = put(d_rot, 0, 0, 256);
    d_rot = put(d_rot, 1, 1, 768);
    d_rot = put(d_rot, 2, 2, 256);
    d_rot = put(d_rot, 3, 3, 256);
    d_rot = put(d_rot, 0, 3, 1000);  // off-diagonal eigenvalue, must be ignored
    e_rot = '0;
    e_rot = put(e_rot, 0, 0, 508);
    e_rot = put(e_rot, 1, 1, 508);
    e_rot = put(e_rot, 0, 1, -257);
    e_rot = put(e_rot, 1, 0, -257);
    e_rot = put(e_rot, 2, 2, 256);
    e_rot = put(e_rot, 3, 3, 256);

    vecs[0] = '{name: "identity", q: q_id, d: d_id, exp: e_id};
    vecs[1] = '{name: "rot45", q: q_rot, d: d_rot, exp: e_rot};
    vecs[2] = '{name: "sat_pos", q: fill(256), d: fill(32767), exp: fill(32767)};
    vecs[3] = '{name: "sat_neg", q: fill(256), d: fill(-32768), exp: fill(-32768)};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk_matrix("reset_matrix", '0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run_once(vecs[v].q, vecs[v].d, lat, bdrop);
      chk({vecs[v].name, "_latency"}, lat, 50);
      chk({vecs[v].name, "_busy_drop"}, bdrop, 0);
      chk({vecs[v].name, "_busy_at_done"}, busy, 0);
      chk_matrix(vecs[v].name, vecs[v].exp);
    end

    // Random vectors, including off-diagonal eigenvalues and wide Q ranges.
    for (int v = 0; v < 8; v++) begin
      rq = '0;
      rd = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (v < 4) rq = put(rq, i, j, int'($urandom_range(0, 512)) - 256);
          else       rq = put(rq, i, j, int'($urandom_range(0, 65535)) - 32768);
          rd = put(rd, i, j, int'($urandom_range(0, 65535)) - 32768);
        end
      end
      run_once(rq, rd, lat, bdrop);
      chk($sformatf("rand%0d_latency", v), lat, 50);
      chk_matrix($sformatf("rand%0d", v), model(rq, rd));
    end

    // Start while busy: second pulse at edge 10 is ignored.
    @(negedge clk);
    eigenvectors = q_id;
    eigenvalues  = d_id;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    dcnt       = 0;
    first_done = -1;
    bdrop      = 0;
    for (int n = 1; n <= 120; n++) begin
      if (n == 10) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        dcnt++;
        if (first_done < 0) first_done = n;
      end
      if (n <= 49 && !busy) bdrop++;
    end
    chk("busy_start_done_count", dcnt, 1);
    chk("busy_start_done_edge", first_done, 50);
    chk("busy_start_busy_drop", bdrop, 0);
    chk("busy_start_idle_after", busy, 0);
    chk_matrix("busy_start", e_id);

    // Reset mid-run.
    @(negedge clk);
    eigenvectors = q_rot;
    eigenvalues  = d_rot;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk_matrix("midrst_matrix", '0);
    @(negedge clk);
    rst   = 1'b0;
    dcnt  = 0;
    bhigh = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (busy) bhigh++;
    end
    chk("midrst_no_done", dcnt, 0);
    chk("midrst_no_busy", bhigh, 0);
    run_once(q_rot, d_rot, lat, bdrop);
    chk("midrst_rerun_latency", lat, 50);
    chk_matrix("midrst_rerun", e_rot);

    // Back-to-back: start held high, second run captures different inputs.
    @(negedge clk);
    eigenvectors = q_id;
    eigenvalues  = d_id;
    start        = 1'b1;
    @(posedge clk);
    #1;
    eigenvectors = q_rot;
    eigenvalues  = d_rot;
    first_done   = -1;
    second_done  = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 52) chk("b2b_busy_second", busy, 1);
      if (done) begin
        if (first_done < 0) begin
          first_done = n;
          chk("b2b_busy_at_first_done", busy, 0);
          chk_matrix("b2b_first", e_id);
        end else begin
          second_done = n;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_edge", first_done, 50);
    chk("b2b_gap", second_done - first_done, 51);
    chk_matrix("b2b_second", e_rot);

    // Result must hold while idle.
    repeat (5) @(posedge clk);
    #1;
    chk_matrix("hold", e_rot);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
